fxp_mac: RTL and testbench

- Streaming fixed-point multiply-accumulate unit with valid/ready handshakes on both the input and output interfaces.
- Each accepted (a, b) pair produces exactly one output beat. That beat carries the running sum of all products accepted since the last reset.
- Sits in the audio datapath (e.g. sinusoid integration). Inputs are signed Q(int_in).(frac_in) samples; the output is a wide signed accumulator.

---
 rtl/fxp_mac_pkg.sv | 26 ++
 rtl/fxp_mac_stage.sv | 49 ++++
 rtl/fxp_mac.sv | 75 +++++++
 tb/tb_fxp_mac.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_mac_pkg.sv
// Shared widths, types and product alignment helper for the fixed-point MAC.
package fxp_mac_pkg;

  localparam int int_in_lp   = 2;
  localparam int frac_in_lp  = 14;
  localparam int int_out_lp  = 10;
  localparam int frac_out_lp = 22;

  localparam int in_w_lp   = int_in_lp + frac_in_lp;
  localparam int prod_w_lp = 2 * in_w_lp;
  localparam int out_w_lp  = int_out_lp + frac_out_lp;

  typedef logic [in_w_lp-1:0]   sample_t;
  typedef logic [prod_w_lp-1:0] prod_t;
  typedef logic [out_w_lp-1:0]  acc_t;

  // The raw product is placed LSB-aligned in the accumulator: sign-extended
  // when the accumulator is wider, truncated when it is narrower. There is
  // deliberately no binary-point realignment.
  function automatic acc_t align_prod(input prod_t p);
    logic signed [prod_w_lp-1:0] ps;
    ps = p;
    return acc_t'(ps);
  endfunction

endpackage

// File: rtl/fxp_mac_stage.sv
// Generic one-entry elastic pipeline register with valid/ready handshakes.
module fxp_mac_stage #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  logic               v_q, v_d;
  logic [width_p-1:0] data_q, data_d;
  logic               load_s;

  // Accept when empty or when the held entry leaves this cycle.
  always_comb begin
    ready_o = !v_q | ready_i;
    load_s  = valid_i & ready_o;
    v_d     = v_q;
    data_d  = data_q;
    if (load_s) begin
      v_d    = 1'b1;
      data_d = data_i;
    end else if (ready_i) begin
      v_d = 1'b0;
    end else begin
      v_d = v_q;
    end
  end

  // Entry state; reset discards any held beat.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign valid_o = v_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fxp_mac.sv
// Streaming signed multiply-accumulate: stage 1 registers the product,
// stage 2 is the running accumulator that is also the output register.
module fxp_mac
  import fxp_mac_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [in_w_lp-1:0]  a_i,
  input  logic [in_w_lp-1:0]  b_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                valid_o,
  output logic [out_w_lp-1:0] data_o,
  input  logic                ready_i
);

  prod_t prod_s;
  prod_t s1_prod_s;
  logic  s1_v_s;
  logic  out_free_s;
  logic  s2_load_s;

  acc_t  acc_q, acc_d;
  logic  valid_o_q, valid_o_d;

  // Full-width signed product of the two input samples.
  always_comb begin
    prod_s = $signed(a_i) * $signed(b_i);
  end

  fxp_mac_stage #(
    .width_p (prod_w_lp)
  ) u_mul_stage (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (prod_s),
    .valid_o (s1_v_s),
    .data_o  (s1_prod_s),
    .ready_i (out_free_s)
  );

  // Accumulate when stage 1 holds a product and the output slot is free;
  // an unconsumed result holds data_o and valid_o steady.
  always_comb begin
    out_free_s = !valid_o_q | ready_i;
    s2_load_s  = s1_v_s & out_free_s;
    acc_d      = acc_q;
    valid_o_d  = valid_o_q;
    if (s2_load_s) begin
      acc_d     = acc_q + align_prod(s1_prod_s);
      valid_o_d = 1'b1;
    end else if (out_free_s) begin
      valid_o_d = 1'b0;
    end else begin
      valid_o_d = valid_o_q;
    end
  end

  // Accumulator and output-valid registers; reset clears the running sum.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q     <= '0;
      valid_o_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      valid_o_q <= valid_o_d;
    end
  end

  assign data_o  = acc_q;
  assign valid_o = valid_o_q;

endmodule

// File: tb/tb_fxp_mac.sv
// Self-checking bench for fxp_mac: vector table plus scoreboard, backpressure
// and mid-stream reset sequences.
module tb_fxp_mac;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] a_i, b_i;
  logic        valid_i, ready_o, valid_o, ready_i;
  logic [31:0] data_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  int in_cnt, out_cnt;
  logic        first_pending;
  logic [31:0] first_prod;
  logic        took;

  typedef struct {
    logic        rst_before;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  fxp_mac dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference product, sign-extended to the 32-bit accumulator.
  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return sa * sb;
  endfunction

  // One clock cycle, starting just after a negedge: drive inputs, evaluate
  // both handshakes before the coming posedge, then wait for the next negedge.
  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic r, input logic [31:0] exp_in, output logic tk);
    logic [31:0] e;
    valid_i = v; a_i = a; b_i = b; ready_i = r;
    #1;
    if (valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h expected none", data_o);
      end else begin
        e = sb_q.pop_front();
        check("data_o", data_o, e);
        if (first_pending) begin
          check("first_after_reset", data_o, first_prod);
          first_pending = 1'b0;
        end
      end
      out_cnt++;
    end
    tk = v && ready_o;
    if (tk) begin
      sb_q.push_back(exp_in);
      in_cnt++;
    end
    @(negedge clk_i);
  endtask

  task automatic drain();
    int n;
    logic t;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 32'h0, t);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    valid_i = 1'b0; ready_i = 1'b0;
    reset_i = 1'b1;
    sb_q.delete();
    #3;
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] hold_v;
    logic [31:0] acc;
    logic [15:0] samp[100];
    int idx, n;
    logic [31:0] p;

    vecs[0]  = '{1'b1, 16'h0001, 16'h0001, 32'h00000001};
    vecs[1]  = '{1'b1, 16'h4000, 16'h4000, 32'h10000000};
    vecs[2]  = '{1'b0, 16'h4000, 16'h4000, 32'h20000000};
    vecs[3]  = '{1'b0, 16'h4000, 16'h4000, 32'h30000000};
    vecs[4]  = '{1'b1, 16'hC000, 16'h4000, 32'hF0000000};
    vecs[5]  = '{1'b0, 16'h4000, 16'h4000, 32'h00000000};
    vecs[6]  = '{1'b1, 16'h4000, 16'h4000, 32'h10000000};
    for (int i = 7; i < 14; i++)
      vecs[i] = '{1'b0, 16'h4000, 16'h4000, 32'((i - 5)) << 28};

    a_i = '0; b_i = '0; valid_i = 1'b0; ready_i = 1'b0;
    in_cnt = 0; out_cnt = 0; first_pending = 1'b0; first_prod = '0;
    reset_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("reset_valid_o", {31'b0, valid_o}, 32'h0);
    check("reset_data_o", data_o, 32'h0);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_reset", {31'b0, ready_o}, 32'h1);

    // Single-beat latency: valid_o low after accept edge, high one edge later.
    cycle(1'b1, 16'h0001, 16'h0001, 1'b0, 32'h00000001, took);
    check("single_accept", {31'b0, took}, 32'h1);
    #1;
    check("latency_n", {31'b0, valid_o}, 32'h0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0, took);
    #1;
    check("latency_n1_valid", {31'b0, valid_o}, 32'h1);
    check("latency_n1_data", data_o, 32'h00000001);
    drain();

    // Vector table: reset where marked, send each beat with ready_i high.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst_before) begin
        drain();
        do_reset();
      end
      n = 0;
      took = 1'b0;
      while (!took && n < 20) begin
        cycle(1'b1, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp, took);
        n++;
      end
      if (!took) begin
        checks++; errors++;
        $display("FAIL accept_timeout: vector %0d not accepted", i);
      end
    end
    drain();

    // Backpressure: three beats offered with ready_i low.
    do_reset();
    cycle(1'b1, 16'h4000, 16'h4000, 1'b0, 32'h10000000, took);
    check("bp_accept1", {31'b0, took}, 32'h1);
    cycle(1'b1, 16'h4000, 16'h4000, 1'b0, 32'h20000000, took);
    check("bp_accept2", {31'b0, took}, 32'h1);
    cycle(1'b1, 16'h4000, 16'h4000, 1'b0, 32'h30000000, took);
    check("bp_full_reject", {31'b0, took}, 32'h0);
    #1;
    hold_v = data_o;
    check("bp_ready_low", {31'b0, ready_o}, 32'h0);
    check("bp_hold_value", hold_v, 32'h10000000);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 16'h4000, 16'h4000, 1'b0, 32'h30000000, took);
      if (took) begin
        checks++; errors++;
        $display("FAIL bp_accept_while_full: got accept expected none");
      end
    end
    #1;
    check("bp_data_stable", data_o, hold_v);
    check("bp_valid_held", {31'b0, valid_o}, 32'h1);
    n = 0;
    took = 1'b0;
    while (!took && n < 10) begin
      cycle(1'b1, 16'h4000, 16'h4000, 1'b1, 32'h30000000, took);
      n++;
    end
    check("bp_third_accept", {31'b0, took}, 32'h1);
    drain();

    // Sinusoid sweep with random handshakes, preceded by a mid-stream reset.
    for (int i = 0; i < 100; i++)
      samp[i] = 16'($rtoi(12000.0 * $sin(6.283185307 * i / 25.0)));
    do_reset();
    acc = '0;
    for (int k = 0; k < 6; k++) begin
      p = ref_prod(16'h2000, 16'h0100);
      acc = acc + p;
      cycle(1'b1, 16'h2000, 16'h0100, 1'($urandom_range(0, 1)), acc, took);
      if (!took) acc = acc - p;
    end
    valid_i = 1'b0;
    reset_i = 1'b1;
    sb_q.delete();
    #1;
    check("midrst_valid_o", {31'b0, valid_o}, 32'h0);
    check("midrst_data_o", data_o, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check("midrst_ready_o", {31'b0, ready_o}, 32'h1);
    @(negedge clk_i);
    in_cnt = 0; out_cnt = 0; acc = '0;
    first_pending = 1'b1;
    first_prod = ref_prod(samp[0], 16'h0001);
    idx = 0; n = 0;
    while (idx < 100 && n < 3000) begin
      p = ref_prod(samp[idx], 16'h0001);
      cycle(1'($urandom_range(0, 3) != 0), samp[idx], 16'h0001,
            1'($urandom_range(0, 2) != 0), acc + p, took);
      if (took) begin
        acc = acc + p;
        idx++;
      end
      n++;
    end
    check("sweep_all_sent", 32'(idx), 32'd100);
    drain();
    check("sweep_out_count", 32'(out_cnt), 32'(in_cnt));
    check("sweep_final_sum", data_o, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
